// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the tdm_demux4 receive path.
//   state_t : framing FSM state (HUNT while searching, LOCKED once aligned)
//   slot_t  : TDM slot index, a..d in the order the select codes s1s0 name them
//   NUM_SLOTS : number of interleaved channels per frame
package tdm_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SLOT_A = 2'd0,
    SLOT_B = 2'd1,
    SLOT_C = 2'd2,
    SLOT_D = 2'd3
  } slot_t;

endpackage

// File: rtl/tdm_chan_shifter.sv
// tdm_chan_shifter: one channel's W-bit word assembler (shift left, MSB first).
//   clk : rising-edge clock
//   clr : synchronous clear; when en is also high the incoming bit becomes
//         the first bit of a fresh word
//   en  : shift d into the LSB this cycle
//   d   : serial data bit
//   nxt : the value the register takes at the next edge; the top level loads
//         its output words from this, so the completing bit is included
module tdm_chan_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] nxt
);

  logic [W-1:0] q;

  always_comb begin
    nxt = q;
    if (clr) begin
      nxt = en ? {{(W-1){1'b0}}, d} : '0;
    end else if (en) begin
      nxt = {q[W-2:0], d};
    end
  end

  always_ff @(posedge clk) begin
    q <= nxt;
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-channel TDM demultiplexer. Aligns a serial one-bit-per-slot
// stream (slot order a, b, c, d) to a frame marker and reassembles each
// channel into W-bit words, presented together with a one-cycle strobe.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   din, din_valid      : serial data bit and its beat qualifier
//   frame_sync          : marks the slot-a beat (only meaningful with din_valid)
//   out_a..out_d        : reassembled words, held until the next completion
//   out_valid           : one-cycle pulse when all four words update
//   slot                : slot the next valid beat is assigned to
//   locked              : framing FSM is in LOCKED
//   sync_err            : one-cycle pulse on a misaligned frame_sync
//
// Build option: define TDM_DEMUX_SYNC_CHECK_EN to realign on a frame_sync seen
// off slot a while LOCKED (pulsing sync_err). Without it, frame_sync is ignored
// once LOCKED and sync_err is constant 0.
//
// Handshake: a beat is transferred on every rising edge where din_valid is
// high; there is no back-pressure. out_valid is a strobe, not a handshake.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic [W-1:0] out_d,
  output logic         out_valid,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err
);

  localparam int FW = $clog2(W);

  state_t                 state;
  slot_t                  slot_q;
  logic [FW-1:0]          frame_q;

  logic                   accept;
  logic                   realign;
  logic                   complete;
  slot_t                  eff_slot;
  logic [NUM_SLOTS-1:0]   sel;
  logic [W-1:0]           sh_nxt [NUM_SLOTS];

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  assign realign = din_valid & frame_sync & (state == LOCKED) & (slot_q != SLOT_A);
`else
  assign realign = 1'b0;
`endif

  // In HUNT only the marked beat is taken; in LOCKED every valid beat is.
  assign accept   = din_valid & ((state == LOCKED) | frame_sync);
  // A realigning beat is treated as slot a regardless of the running count.
  // In HUNT slot_q is always SLOT_A, so the sync beat also lands in slot a.
  assign eff_slot = realign ? SLOT_A : slot_q;
  assign sel      = accept ? (NUM_SLOTS'(1) << eff_slot) : '0;
  assign complete = accept & (eff_slot == SLOT_D) & (frame_q == FW'(W - 1));

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_chan
    tdm_chan_shifter #(.W(W)) u_shifter (
      .clk (clk),
      .clr (rst | realign),
      .en  (sel[i]),
      .d   (din),
      .nxt (sh_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      slot_q    <= SLOT_A;
      frame_q   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_d     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= complete;
      if (accept) begin
        state  <= LOCKED;
        slot_q <= slot_t'(2'(eff_slot + 2'd1));
        if (realign || complete) begin
          frame_q <= '0;
        end else if (eff_slot == SLOT_D) begin
          frame_q <= frame_q + 1'b1;
        end
        if (complete) begin
          out_a <= sh_nxt[0];
          out_b <= sh_nxt[1];
          out_c <= sh_nxt[2];
          out_d <= sh_nxt[3];
        end
      end
    end
  end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= realign;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

  assign slot   = slot_q;
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench for tdm_demux4 (W=8). Expected word sets are
// queued when a full set is driven and compared when out_valid is seen.
// Honours TDM_DEMUX_SYNC_CHECK_EN for the misalignment scenario.
module tb_tdm_demux4;

  localparam int W = 8;
  typedef logic [3:0][W-1:0] set_t;  // index 0 = channel a

  logic         clk;
  logic         rst;
  logic         din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         out_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         sync_err;

  tdm_demux4 #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_valid  (out_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int vld_cnt = 0;
  int exp_vld = 0;
  logic [4*W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop on every out_valid
  always @(negedge clk) begin
    logic [4*W-1:0] e;
    if (out_valid === 1'b1) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_words", {32'd0, out_a, out_b, out_c, out_d}, {32'd0, e});
      end
    end
  end

  // driver tasks (called at a negative edge, return at the negative edge
  // following the sampling edge)
  task automatic beat(input logic b, input logic fs);
    din        = b;
    din_valid  = 1'b1;
    frame_sync = fs;
    @(negedge clk);
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic push(input set_t s);
    exp_q.push_back({s[0], s[1], s[2], s[3]});
    exp_vld++;
  endtask

  task automatic send_set(input set_t s, input int start, input int stop,
                          input logic fs_first, input logic gapped);
    for (int k = start; k < stop; k++) begin
      beat(s[k % 4][W - 1 - k / 4], fs_first && (k == start));
      if (fs_first && (k == start)) chk("locked_on_sync", {63'd0, locked}, 64'd1);
      if (gapped && (k < stop - 1)) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic check_cnt(input string tag);
    #1;
    chk(tag, 64'(vld_cnt), 64'(exp_vld));
  endtask

  task automatic check_done(input string tag, input set_t s);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_words"}, {32'd0, out_a, out_b, out_c, out_d},
        {32'd0, s[0], s[1], s[2], s[3]});
    @(negedge clk);
    chk({tag, "_pulse_end"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_hold"}, {32'd0, out_a, out_b, out_c, out_d},
        {32'd0, s[0], s[1], s[2], s[3]});
    check_cnt({tag, "_count"});
  endtask

  set_t s1, s2, p, q, s3, s4;
`ifndef TDM_DEMUX_SYNC_CHECK_EN
  set_t m;
`endif

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    s1[0] = 8'hA5; s1[1] = 8'h3C; s1[2] = 8'hFF; s1[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      s2[i] = W'($urandom_range(0, 255));
      p[i]  = W'($urandom_range(0, 255));
      q[i]  = W'($urandom_range(0, 255));
      s3[i] = W'($urandom_range(0, 255));
      s4[i] = W'($urandom_range(0, 255));
    end

    // reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_out_a", {56'd0, out_a}, 64'd0);
    chk("rst_out_b", {56'd0, out_b}, 64'd0);
    chk("rst_out_c", {56'd0, out_c}, 64'd0);
    chk("rst_out_d", {56'd0, out_d}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_slot", {62'd0, slot}, 64'd0);
    chk("rst_sync_err", {63'd0, sync_err}, 64'd0);

    // basic frame set
    push(s1);
    send_set(s1, 0, 32, 1'b1, 1'b0);
    check_done("basic", s1);

    // hunt discard after a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("hunt_rst_locked", {63'd0, locked}, 64'd0);
    chk("hunt_rst_out_a", {56'd0, out_a}, 64'd0);
    for (int i = 0; i < 5; i++) beat(1'($urandom_range(0, 1)), 1'b0);
    chk("hunt_locked", {63'd0, locked}, 64'd0);
    chk("hunt_slot", {62'd0, slot}, 64'd0);
    push(s1);
    send_set(s1, 0, 32, 1'b1, 1'b0);
    check_done("hunt", s1);

    // gapped input
    push(s1);
    send_set(s1, 0, 32, 1'b1, 1'b1);
    check_done("gapped", s1);

    // another pattern, no frame_sync while locked
    push(s2);
    send_set(s2, 0, 32, 1'b0, 1'b0);
    check_done("rand", s2);

    // misaligned frame_sync on the slot-c beat
    send_set(p, 0, 10, 1'b0, 1'b0);
    chk("mis_slot_before", {62'd0, slot}, 64'd2);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    push(q);
    send_set(q, 0, 1, 1'b1, 1'b0);
    chk("mis_sync_err", {63'd0, sync_err}, 64'd1);
    chk("mis_slot_after", {62'd0, slot}, 64'd1);
    chk("mis_no_valid", {63'd0, out_valid}, 64'd0);
    send_set(q, 1, 2, 1'b0, 1'b0);
    chk("mis_sync_err_end", {63'd0, sync_err}, 64'd0);
    send_set(q, 2, 32, 1'b0, 1'b0);
    check_done("realign", q);
`else
    for (int k = 0; k < 32; k++) begin
      m[k % 4][W - 1 - k / 4] = (k < 10) ? p[k % 4][W - 1 - k / 4]
                                         : q[(k - 10) % 4][W - 1 - (k - 10) / 4];
    end
    push(m);
    send_set(q, 0, 1, 1'b1, 1'b0);
    chk("mis_sync_err", {63'd0, sync_err}, 64'd0);
    chk("mis_slot_after", {62'd0, slot}, 64'd3);
    send_set(q, 1, 22, 1'b0, 1'b0);
    check_done("noalign", m);
    send_set(q, 22, 32, 1'b0, 1'b0);
    check_cnt("noalign_tail_count");
`endif

    // reset mid-word
    send_set(s3, 0, 20, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_locked", {63'd0, locked}, 64'd0);
    chk("mid_rst_slot", {62'd0, slot}, 64'd0);
    chk("mid_rst_out_a", {56'd0, out_a}, 64'd0);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (5) @(negedge clk);
    check_cnt("mid_rst_no_stale");
    push(s4);
    send_set(s4, 0, 32, 1'b1, 1'b0);
    check_done("post_rst", s4);

    repeat (10) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    check_cnt("final_count");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
